seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Parametrised multiplexed seven-segment display driver for NUM_DIGITS common-anode digits. It accepts packed hex nibbles plus per-digit decimal-point and blank masks, and scans one digit at a time at a programmable slot rate. It adds PWM brightness control, leading-zero suppression and tear-free frame-synchronous input capture. It is the successor to the fixed four-digit scanner and drives board anode/cathode pins directly.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SLOT_LOG2, 16, log2 of clock cycles per digit slot
- BRIGHT_W, 4, brightness code width (1..SLOT_LOG2)

- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- val  input  4*NUM_DIGITS  hex nibble per digit; val[3:0] is digit 0, the rightmost and least significant
- dp_in  input  NUM_DIGITS  per-digit decimal point request, 1 = lit
- blank  input  NUM_DIGITS  per-digit force-off, 1 = anode never driven
- lz_en  input  1  leading-zero suppression enable
- bright  input  BRIGHT_W  on-time code; all-ones = 100 %
- an  output  NUM_DIGITS  anode enables, active low
- seg  output  7  cathodes a..g as seg[6]..seg[0], active low
- dp  output  1  decimal-point cathode, active low
- frame_tick  output  1  one-cycle pulse at the start of each frame

## Operation
- Prescaler `pcnt` (SLOT_LOG2 bits) increments every cycle and wraps at 2^SLOT_LOG2-1 -> 0.
- Slot counter `slot` advances when `pcnt` wraps. It runs 0..NUM_DIGITS-1, then 0.
- Shadow capture: when `pcnt`==0 and `slot`==0, val, dp_in, blank, lz_en and bright load into shadow registers. This includes the first cycle after reset release. All decode logic uses only the shadow registers, so input changes mid-frame have no visible effect until the next frame.
- Leading-zero suppression, when shadow lz_en = 1: digit i (i ≥ 1) is suppressed if its nibble and all higher nibbles are 0. Digit 0 is never suppressed. A suppressed digit shows segments off, but dp is still shown if requested.
- Digit lit condition: blank[slot]=0 and pcnt[SLOT_LOG2-1 -: BRIGHT_W] ≤ bright. The matching `an` bit goes low; all other `an` bits stay high.
- When the anode is off, seg = 7'h7F and dp = 1.
- Hex decode (abcdefg, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- dp = ~dp_in[slot] while the digit is lit.

## Timing
- All outputs are registered and reflect the counter and shadow state of the previous cycle: one cycle of latency. an, seg and dp change on the same edge, so there is no ghosting skew.
- Asynchronous reset (rst_n low, with no clock edge required):
  - an = all ones, seg = 7'h7F, dp = 1, frame_tick = 0
  - pcnt = 0, slot = 0, shadow registers = 0
- Slot length is 2^SLOT_LOG2 cycles. Frame length is NUM_DIGITS·2^SLOT_LOG2 cycles.
- frame_tick is high for exactly one cycle, on the same edge where outputs first show slot 0 of a new frame.
- Lit cycles per slot = (bright+1)·2^(SLOT_LOG2-BRIGHT_W). The lit cycles come first in the slot.
- Slot wrap, prescaler wrap and shadow load in the same cycle are a single event. The new shadow values apply from the first output cycle of slot 0.
- Reset asserted mid-frame aborts the scan immediately. After release, scanning restarts at slot 0, pcnt 0, with a fresh shadow capture.

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_LOG2=3, BRIGHT_W=2.
- **Reset and scan order.** Hold rst_n low 5 cycles with bright=3, then release.
  - While low: an=1111, seg=7F, dp=1.
  - After release, an steps 1110, 1101, 1011, 0111, each for 8 cycles.
  - frame_tick pulses every 32 cycles.
- **Hex decode.** val=16'h12AF, bright=3, dp_in=4'b0100.
  - Slot 0: seg=0111000. Slot 1: seg=0001000. Slot 2: seg=0010010 with dp=0. Slot 3: seg=1001111.
- **Brightness.** bright=0 -> anode low for 2 of every 8 cycles per slot. bright=1 -> 4 of 8. bright=3 -> 8 of 8.
- **Leading-zero suppression and blank.**
  - lz_en=1, val=16'h0050 -> digits 3 and 2 show seg=7F; digit 1 shows 0100100; digit 0 shows 0000001.
  - lz_en=1, val=0 -> only digit 0 lit.
  - blank=4'b0001 -> an[0] never low.
- **Tear-free capture.** Change val from 16'h1111 to 16'h2222 during slot 2. The remaining slots of that frame still show 1; the next frame shows 2 on all digits.
- **Reset mid-operation.** Pull rst_n low during slot 2, between clock edges. Outputs go to reset values immediately. After release, scanning restarts at an=1110 and the shadow registers reload.

Source files
------------

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Multiplexed seven-segment driver for NUM_DIGITS common-anode
//             digits. It scans one digit per slot and provides PWM
//             brightness, leading-zero suppression and frame-synchronous
//             (tear-free) capture of the display inputs.
//
//  Ports
//    clk         system clock
//    rst_n       asynchronous, active-low reset
//    val         packed hex nibbles; val[3:0] is digit 0 (rightmost)
//    dp_in       per-digit decimal-point request, 1 = lit
//    blank       per-digit force-off, 1 = anode never driven
//    lz_en       leading-zero suppression enable
//    bright      on-time code; all-ones = 100 %
//    an          anode enables, active low
//    seg         cathodes a..g on seg[6]..seg[0], active low
//    dp          decimal-point cathode, active low
//    frame_tick  one-cycle pulse when slot 0 of a new frame is first shown
//
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_LOG2  = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                    c_SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_SLOT_W-1:0]   c_LAST_SLOT = c_SLOT_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_OFF   = 7'h7F;

    // ------------------------------------------------------------------------
    // Hex to segment pattern (abcdefg, 0 = segment lit)
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------------
    logic [SLOT_LOG2-1:0] r_pcnt;
    logic [c_SLOT_W-1:0]  r_slot;
    logic                 w_pcnt_wrap;
    logic                 w_last_slot;
    logic                 w_load;

    assign w_pcnt_wrap = &r_pcnt;
    assign w_last_slot = (r_slot == c_LAST_SLOT);
    // Start of frame: the shadow registers capture the inputs here.
    assign w_load      = (r_pcnt == '0) && (r_slot == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_slot <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            if (w_pcnt_wrap) begin
                r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_lz_en;
    logic [BRIGHT_W-1:0]     r_bright;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val    <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_lz_en  <= 1'b0;
            r_bright <= '0;
        end else if (w_load) begin
            r_val    <= val;
            r_dp     <= dp_in;
            r_blank  <= blank;
            r_lz_en  <= lz_en;
            r_bright <= bright;
        end
    end

    // The capture cycle is also the first cycle of slot 0. Its output must
    // already use the freshly captured values, so during that one cycle the
    // decode path takes the live inputs instead of the (still old) shadow.
    logic [4*NUM_DIGITS-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_lz_en;
    logic [BRIGHT_W-1:0]     w_bright;

    assign w_val    = w_load ? val    : r_val;
    assign w_dp     = w_load ? dp_in  : r_dp;
    assign w_blank  = w_load ? blank  : r_blank;
    assign w_lz_en  = w_load ? lz_en  : r_lz_en;
    assign w_bright = w_load ? bright : r_bright;

    // ------------------------------------------------------------------------
    // Per-digit nibbles and leading-zero detection
    // ------------------------------------------------------------------------
    logic [3:0]            w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_hi_zero;   // bit i: nibbles i..top are all zero
    logic                  w_acc;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = w_val[4*gi +: 4];
        end
    endgenerate

    // Walk from the most significant digit down, accumulating "all zero so far".
    always_comb begin
        w_hi_zero = '0;
        w_acc     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc        = w_acc & (w_nib[i] == 4'h0);
            w_hi_zero[i] = w_acc;
        end
    end

    // ------------------------------------------------------------------------
    // Current-slot decode
    // ------------------------------------------------------------------------
    logic [3:0]            w_cur_nib;
    logic [BRIGHT_W-1:0]   w_pwm_phase;
    logic                  w_lit;
    logic                  w_suppress;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [6:0]            w_seg_next;
    logic                  w_dp_next;

    assign w_cur_nib   = w_nib[r_slot];
    // The top BRIGHT_W prescaler bits form the PWM phase, so the lit part of
    // the slot is contiguous and comes first.
    assign w_pwm_phase = r_pcnt[SLOT_LOG2-1 -: BRIGHT_W];
    assign w_lit       = ~w_blank[r_slot] & (w_pwm_phase <= w_bright);
    // Digit 0 always shows, even for a value of zero.
    assign w_suppress  = w_lz_en & (r_slot != '0) & w_hi_zero[r_slot];

    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_slot == c_SLOT_W'(i))) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    // A suppressed digit keeps its anode (and decimal point) but blanks the
    // seven segments.
    assign w_seg_next = (w_lit && !w_suppress) ? hex_to_seg(w_cur_nib) : c_SEG_OFF;
    assign w_dp_next  = w_lit ? ~w_dp[r_slot] : 1'b1;

    // ------------------------------------------------------------------------
    // Output registers: all pins update on the same edge (no ghosting skew)
    // ------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic                  r_frame_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= '1;
            r_seg        <= c_SEG_OFF;
            r_dp_out     <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_dp_out     <= w_dp_next;
            r_frame_tick <= w_load;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp_out;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Self-checking bench for seven_seg_scan (4 digits, 8-cycle
//             slots, 2-bit brightness). Directed steps followed by random
//             input changes, compared against a behavioural display model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int c_ND   = 4;
    localparam int c_SL   = 3;
    localparam int c_BW   = 2;
    localparam int c_SLOT = 1 << c_SL;       // cycles per slot
    localparam int c_FRM  = c_ND * c_SLOT;   // cycles per frame

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4*c_ND-1:0] val;
    logic [c_ND-1:0]   dp_in;
    logic [c_ND-1:0]   blank;
    logic              lz_en;
    logic [c_BW-1:0]   bright;
    logic [c_ND-1:0]   an;
    logic [6:0]        seg;
    logic              dp;
    logic              frame_tick;

    seven_seg_scan #(
        .NUM_DIGITS (c_ND),
        .SLOT_LOG2  (c_SL),
        .BRIGHT_W   (c_BW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .val        (val),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_en      (lz_en),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Segment patterns for 0..F, abcdefg, 0 = lit.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model state: cycles elapsed since reset release plus frame snapshot.
    int              t;
    logic [15:0]     m_val;
    logic [3:0]      m_dp;
    logic [3:0]      m_blank;
    logic            m_lz;
    logic [1:0]      m_bright;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".an"},  16'(an),         16'hF);
        chk({tag, ".seg"}, 16'(seg),        16'h7F);
        chk({tag, ".dp"},  16'(dp),         16'h1);
        chk({tag, ".ft"},  16'(frame_tick), 16'h0);
    endtask

    // One clock cycle: predict what the display shows for cycle t of the
    // frame schedule, clock once, then compare.
    task automatic step();
        int         p, s;
        logic       lit, sup;
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_ft;
        if (t % c_FRM == 0) begin
            m_val = val; m_dp = dp_in; m_blank = blank; m_lz = lz_en; m_bright = bright;
        end
        p   = t % c_SLOT;
        s   = (t / c_SLOT) % c_ND;
        lit = !m_blank[s] && (p < (int'(m_bright) + 1) * (c_SLOT >> c_BW));
        nib = m_val[4*s +: 4];
        sup = m_lz && (s >= 1) && ((m_val >> (4*s)) == 16'h0);
        e_an  = lit ? ~(4'b0001 << s) : 4'hF;
        e_seg = (lit && !sup) ? seg_tab[nib] : 7'h7F;
        e_dp  = lit ? ~m_dp[s] : 1'b1;
        e_ft  = (t % c_FRM == 0);
        @(posedge clk);
        #1;
        t++;
        chk("an",  16'(an),         16'(e_an));
        chk("seg", 16'(seg),        16'(e_seg));
        chk("dp",  16'(dp),         16'(e_dp));
        chk("ft",  16'(frame_tick), 16'(e_ft));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_slot(input int sl);
        while (((t % c_FRM) / c_SLOT) != sl) step();
    endtask

    initial begin
        rst_n  = 1'b1;
        val    = 16'h0000;
        dp_in  = 4'h0;
        blank  = 4'h0;
        lz_en  = 1'b0;
        bright = 2'd3;
        t      = 0;

        // Reset: asserted away from a clock edge, held five cycles.
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk_reset("rst_hold");
        end
        #4 rst_n = 1'b1;   // released mid-cycle
        t = 0;

        // Scan order and frame_tick at full brightness.
        run(2 * c_FRM);

        // Hex decode with a decimal point on digit 2.
        val = 16'h12AF; dp_in = 4'b0100;
        run(2 * c_FRM);

        // Brightness levels.
        bright = 2'd0; run(2 * c_FRM);
        bright = 2'd1; run(2 * c_FRM);
        bright = 2'd3; dp_in = 4'h0; run(c_FRM);

        // Leading-zero suppression and blanking.
        lz_en = 1'b1; val = 16'h0050; dp_in = 4'b1000; run(2 * c_FRM);
        val = 16'h0000; dp_in = 4'h0; run(2 * c_FRM);
        lz_en = 1'b0; blank = 4'b0001; val = 16'h4321; run(2 * c_FRM);
        blank = 4'h0;

        // Tear-free capture: change the value mid-frame in slot 2.
        val = 16'h1111; run(c_FRM);
        run_to_slot(2); run(3);
        val = 16'h2222; run(2 * c_FRM);

        // Reset during slot 2, between clock edges.
        run_to_slot(2); run(2);
        #3 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        val = 16'h9876; dp_in = 4'b0010; bright = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk_reset("rst_mid_hold");
        end
        #4 rst_n = 1'b1;
        t = 0;
        run(2 * c_FRM);

        // Random inputs applied at arbitrary points in the frame.
        for (int k = 0; k < 30; k++) begin
            val    = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp_in  = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_en  = 1'($urandom);
            bright = 2'($urandom);
            run($urandom_range(1, 48));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
